// File: rtl/firmware_loader.sv
// firmware_loader: Avalon-MM master that loads a byte stream into firmware memory, then reads it back.
// Latency: a write one cycle after each 4th byte; done NUM_WORDS+2 cycles after the last write.
// Backpressure: byte_ready is high only in LOAD, so the source stalls during each one-cycle write and after loading.
module firmware_loader #(
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 896
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic              mem_clken,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  // One extra bit so the counter can hold NUM_WORDS == 2^ADDR_W without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_VERIFY, S_CHECK, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wsum_q, wsum_d;
  logic [31:0]      rsum_q, rsum_d;

  logic start_ok;
  logic byte_acc;
  logic last_idx;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign byte_acc = (state_q == S_LOAD) && byte_valid;
  assign last_idx = (cnt_q == LAST_IDX);

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
    end
  end

  // Next-state sequencing: load words, verify them all, then report.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD:         if (byte_acc && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:        state_d = last_idx ? S_VERIFY : S_LOAD;
      S_VERIFY:       if (last_idx) state_d = S_CHECK;
      S_CHECK:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath: byte packing, shared word/read counter, and both running sums.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    if (start_ok) begin
      byte_cnt_d = '0;
      word_d     = '0;
      cnt_d      = '0;
      wsum_d     = '0;
      rsum_d     = '0;
    end else begin
      // Shifting in from the top leaves the first byte in [7:0] after four bytes.
      if (byte_acc) begin
        word_d     = {byte_data, word_q[31:8]};
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
      // The counter is rewound after the last write so verify reads start at 0.
      if (state_q == S_WRITE) begin
        wsum_d = wsum_q + word_q;
        cnt_d  = last_idx ? '0 : cnt_q + CNT_ONE;
      end
      if (state_q == S_VERIFY) cnt_d = cnt_q + CNT_ONE;
      // Read data trails its address by one cycle; CHECK takes the final word.
      if ((state_q == S_VERIFY && cnt_q != '0) || state_q == S_CHECK)
        rsum_d = rsum_q + mem_readdata;
    end
  end

  // Output decode from the current state.
  always_comb begin
    byte_ready      = (state_q == S_LOAD);
    mem_chipselect  = (state_q == S_WRITE) || (state_q == S_VERIFY);
    mem_write       = (state_q == S_WRITE);
    mem_debugaccess = (state_q == S_WRITE);
    mem_byteenable  = mem_chipselect ? 4'hF : 4'h0;
    mem_address     = mem_chipselect ? cnt_q[ADDR_W-1:0] : '0;
    mem_writedata   = (state_q == S_WRITE) ? word_q : '0;
    busy            = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                      (state_q == S_VERIFY) || (state_q == S_CHECK);
    mem_clken       = busy;
    done            = (state_q == S_DONE);
    error           = done && (rsum_q != wsum_q);
    checksum        = done ? wsum_q : '0;
  end

endmodule

// File: tb/tb_firmware_loader.sv
// Testbench for firmware_loader: random byte stream, memory model, scoreboard monitor.
// Expected writes/reads/results are queued by stimulus and popped by an independent monitor.
// Covers reset, packing/stall, full load, read-back error, async reset mid-load, start handling.
module tb_firmware_loader;
  localparam int ADDR_W    = 10;
  localparam int NUM_WORDS = 896;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              busy, done, error;
  logic [31:0]       checksum;

  always #5 clk = ~clk;

  firmware_loader #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_debugaccess(mem_debugaccess), .mem_clken(mem_clken),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: writes store, reads return data the following cycle.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q;
  bit          flip5 = 1'b0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else rd_q <= mem[mem_address] ^ ((flip5 && mem_address == 5) ? 32'h1 : 32'h0);
    end
  end
  assign mem_readdata = rd_q;

  // Scoreboard queues.
  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t               exp_wr [$];
  logic [ADDR_W-1:0] exp_rd [$];
  logic [32:0]       exp_res[$];

  logic [31:0] img [0:NUM_WORDS-1];

  wire outs_any = |{byte_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
                    mem_debugaccess, mem_clken, mem_writedata, busy, done, error, checksum};

  // Monitor: compares every memory access and each done rising edge.
  initial begin
    int cyc, last_wr_cyc, last_mem_cyc;
    logic done_prev;
    wr_t e;
    logic [ADDR_W-1:0] ra;
    logic [32:0] r;
    cyc = 0; last_wr_cyc = 0; last_mem_cyc = -1; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        done_prev = 1'b0;
        last_mem_cyc = -1;
      end else begin
        if (busy && done) check("busy_done_excl", 1, 0);
        if (mem_chipselect && mem_write) begin
          if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", mem_address, e.addr);
            check("wr_data", mem_writedata, e.data);
            check("wr_debugaccess", mem_debugaccess, 1);
            check("wr_byteenable", mem_byteenable, 4'hF);
            check("wr_byte_ready", byte_ready, 0);
          end
          last_wr_cyc = cyc;
          last_mem_cyc = cyc;
        end else if (mem_chipselect) begin
          if (exp_rd.size() == 0) check("unexpected_read", 1, 0);
          else begin
            ra = exp_rd.pop_front();
            check("rd_addr", mem_address, ra);
            check("rd_consecutive", cyc, last_mem_cyc + 1);
            check("rd_byteenable", mem_byteenable, 4'hF);
            check("rd_clken", mem_clken, 1);
          end
          last_mem_cyc = cyc;
        end
        if (done && !done_prev) begin
          check("done_latency", cyc - last_wr_cyc, NUM_WORDS + 2);
          if (exp_res.size() == 0) check("unexpected_done", 1, 0);
          else begin
            r = exp_res.pop_front();
            check("result_error", error, r[32]);
            check("result_checksum", checksum, r[31:0]);
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g, guard;
    bit acc;
    g = $urandom_range(0, maxgap);
    repeat (g) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      acc = byte_ready;
      tick();
      guard++;
    end
    if (!acc) check("byte_accept_timeout", 0, 1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, input bit chk_stall);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], maxgap);
    if (chk_stall) begin
      check("ready_low_after_4th", byte_ready, 0);
      tick();
      check("ready_back_high", byte_ready, 1);
    end
  endtask

  task automatic run_load(input int nwords, input int maxgap0, input bit poke_start,
                          input bit exp_err, input logic [31:0] exp_csum);
    if (nwords == NUM_WORDS) begin
      for (int k = 0; k < NUM_WORDS; k++) exp_rd.push_back(ADDR_W'(k));
      exp_res.push_back({exp_err, exp_csum});
    end
    pulse_start();
    check("start_ready", byte_ready, 1);
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_error_clr", error, 0);
    for (int k = 0; k < nwords; k++) begin
      exp_wr.push_back(wr_t'({ADDR_W'(k), img[k]}));
      if (poke_start && k == 300) begin
        tick();
        pulse_start();
      end
      send_word(img[k], (k == 0) ? maxgap0 : 1, (k == 0) || (k == nwords / 2));
    end
    if (poke_start) begin
      repeat (10) tick();
      check("verify_busy_before_poke", busy, 1);
      pulse_start();
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 3000) begin
      tick();
      guard++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    logic [31:0] s;
    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      start      = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      @(negedge clk);
      check("reset_outputs", outs_any, 0);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    // Bytes without start must be ignored.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nostart_ready", byte_ready, 0);
      check("nostart_cs", mem_chipselect, 0);
    end
    byte_valid = 1'b0;

    // Run A: random image, first word 0x44332211 with gapped bytes, start poked in LOAD and VERIFY.
    flip5 = 1'b0;
    s = 32'h0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      img[k] = (k == 0) ? 32'h44332211 : $urandom;
      s += img[k];
    end
    run_load(NUM_WORDS, 3, 1'b1, 1'b0, s);
    wait_done();

    // Run B: word k = k, started from DONE.
    for (int k = 0; k < NUM_WORDS; k++) img[k] = 32'(k);
    run_load(NUM_WORDS, 1, 1'b0, 1'b0, 32'h00061E40);
    wait_done();

    // Run C: read-back of address 5 corrupted.
    flip5 = 1'b1;
    run_load(NUM_WORDS, 1, 1'b0, 1'b1, 32'h00061E40);
    wait_done();
    check("error_level", error, 1);

    // Run D: start from DONE (error clears), reset after 100 words.
    flip5 = 1'b0;
    run_load(100, 1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("busy_before_reset", busy, 1);
    check("wr_queue_drained", exp_wr.size(), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_any, 0);
    exp_wr.delete();
    exp_rd.delete();
    exp_res.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", busy, 0);

    // Run E: full reload after reset must start at address 0 and pass.
    run_load(NUM_WORDS, 1, 1'b0, 1'b0, 32'h00061E40);
    wait_done();
    tick();
    check("final_wr_queue_empty", exp_wr.size(), 0);
    check("final_rd_queue_empty", exp_rd.size(), 0);
    check("final_res_queue_empty", exp_res.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/firmware_loader.md
# firmware_loader

Avalon-MM master that fills the on-chip firmware memory from a byte stream (UART/JTAG receiver side), then reads the whole image back to verify it. It drives the memory's slave port with `debugaccess` asserted so writes land in the otherwise read-only firmware store. On completion it reports a 32-bit additive checksum and a pass/fail flag.

## Interface
Parameters:
- `ADDR_W`, 10: memory word-address width.
- `NUM_WORDS`, 896: words loaded and verified, with 1 ≤ NUM_WORDS ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_address`  out  ADDR_W  word address.
- `mem_byteenable`  out  4  always 4'hF when `mem_chipselect`=1, else 0.
- `mem_chipselect`  out  1  memory access strobe.
- `mem_write`  out  1  write strobe.
- `mem_debugaccess`  out  1  high with every write.
- `mem_clken`  out  1  memory clock enable; 1 whenever busy.
- `mem_writedata`  out  32  write word.
- `mem_readdata`  in  32  read word, valid the cycle after the address cycle (unregistered output, 1-cycle latency).
- `busy`  out  1  high in LOAD/WRITE/VERIFY/CHECK.
- `done`  out  1  level; high in DONE.
- `error`  out  1  verify mismatch; valid while `done`=1.
- `checksum`  out  32  sum of all written words mod 2^32; valid while `done`=1.

## Operation
- Reset values: every output is 0. State is IDLE; the byte counter, word counter, write sum and read sum are all 0.
- IDLE: `start` moves to LOAD and clears the counters and sums.
- DONE: `start` moves to LOAD and clears `done` and `error`.
- LOAD: `byte_ready`=1. A byte is accepted when `byte_valid` & `byte_ready`.
  - Bytes are packed little-endian: the first byte goes to [7:0] and the fourth to [31:24].
  - On the 4th accepted byte, move to WRITE.
- WRITE, exactly one cycle:
  - Outputs: `mem_chipselect`=`mem_write`=`mem_debugaccess`=1, `mem_address`=word counter, `mem_writedata`=assembled word, `byteenable`=4'hF, `byte_ready`=0.
  - The word is added to the write sum and the word counter increments.
  - Next state is LOAD, or VERIFY if this was word NUM_WORDS-1.
- VERIFY:
  - Issues reads at addresses 0..NUM_WORDS-1, one per cycle, with `chipselect`=1 and `write`=0.
  - `mem_readdata` is captured the cycle after each address and added to the read sum.
  - After the last address, go to CHECK for one cycle; it absorbs the final read data.
- CHECK → DONE. In DONE, `error` = (read sum ≠ write sum) and `checksum` = write sum.
- `start` while busy is ignored.
- Sums wrap modulo 2^32 with no overflow flag.
- `byte_valid` is ignored outside LOAD. Excess bytes are the source's responsibility.
- Reset mid-operation returns to reset values immediately. Memory contents are then undefined and must be reloaded.
- `mem_address` wraps never; NUM_WORDS ≤ 2^ADDR_W is required by the parameter rule.

## Timing
- LOAD is entered the cycle after `start`. `byte_ready` is 1 in that cycle.
- If the 4th byte is accepted in cycle T:
  - The write occurs in cycle T+1.
  - `byte_ready`=0 in T+1 and returns to 1 in T+2.
  - Peak rate is 4 bytes per 5 cycles.
- If the last write is in cycle W:
  - Read addresses are issued in W+1..W+NUM_WORDS.
  - Read data is captured in W+2..W+NUM_WORDS+1; the last capture happens in CHECK.
  - `done`=1 from W+NUM_WORDS+2.
- `busy` and `done` are never high together. `busy` falls in the same cycle `done` rises.
- `mem_clken` follows `busy`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → all outputs 0. Release, then assert `byte_valid` without `start` → no memory access and `byte_ready`=0.
- Packing and stall:
  - `start`, then bytes 0x11,0x22,0x33,0x44 with `byte_valid` gaps of 0–3 cycles → one write, address 0, writedata 0x44332211, debugaccess=1, byteenable=F.
  - `byte_ready` is low for exactly one cycle after the 4th byte.
- Full load: NUM_WORDS=896, word k = k, backed by a memory model with 1-cycle read latency.
  - 896 writes to addresses 0..895.
  - 896 reads to addresses 0..895 in consecutive cycles.
  - `done` is high NUM_WORDS+2 cycles after the last write, with `error`=0 and `checksum`=0x00061E40.
- Error injection: the model flips bit 0 of the address-5 readback → `done`=1, `error`=1, `checksum` unchanged (0x00061E40).
- Reset mid-load: after 100 words, pulse `reset_n` low → outputs go to 0 asynchronously. A new `start` and full load then writes from address 0 and passes.
- Start handling:
  - `start` pulsed during LOAD and during VERIFY → ignored; the sequence and the final result are unchanged.
  - `start` in DONE → `done` and `error` clear the next cycle and a new load begins.
